// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Optional ILLEGAL_OP_TRAP_EN: unknown opcodes halt the core and set o_illegal.
module riscv_multicycle_ctrl (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    output logic       o_pcWrite,
    output logic       o_adrSrc,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regWrite,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [3:0] o_aluOp,
    output logic       o_retire,
    output logic       o_illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_DMEM = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] A_PC     = 2'b00;
    localparam logic [1:0] A_OLDPC  = 2'b01;
    localparam logic [1:0] A_REG1   = 2'b10;
    localparam logic [1:0] B_REG2   = 2'b00;
    localparam logic [1:0] B_IMM    = 2'b01;
    localparam logic [1:0] B_FOUR   = 2'b10;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
`ifdef ILLEGAL_OP_TRAP_EN
        S_JAL,
        S_HALT
`else
        S_JAL
`endif
    } state_t;

    state_t state;
    state_t state_nxt;

    logic f3_legal;
    logic op_known;

    assign f3_legal = i_funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
    assign op_known = i_opcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL};

    always_ff @(posedge i_clk) begin
        if (i_srst) state <= S_FETCH;
        else        state <= state_nxt;
    end

`ifdef ILLEGAL_OP_TRAP_EN
    always_ff @(posedge i_clk) begin
        if (i_srst)
            o_illegal <= 1'b0;
        else if (state == S_DECODE && !op_known)
            o_illegal <= 1'b1;
    end
`else
    assign o_illegal = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        o_pcWrite   = 1'b0;
        o_adrSrc    = 1'b0;
        o_memWrite  = 1'b0;
        o_irWrite   = 1'b0;
        o_regWrite  = 1'b0;
        o_resultSrc = RES_ALU;
        o_aluSrcA   = A_PC;
        o_aluSrcB   = B_REG2;
        o_aluOp     = ALU_ADD;
        o_retire    = 1'b0;
        unique case (state)
            S_FETCH: begin
                o_irWrite   = 1'b1;
                o_pcWrite   = 1'b1;
                o_aluSrcB   = B_FOUR;
                o_resultSrc = RES_PC4;
                state_nxt   = S_DECODE;
            end
            S_DECODE: begin
                o_aluSrcA = A_OLDPC;
                o_aluSrcB = B_IMM;
                unique case (1'b1)
                    i_opcode == OP_LW,
                    i_opcode == OP_SW:  state_nxt = S_MEMADR;
                    i_opcode == OP_R:   state_nxt = S_EXECUTER;
                    i_opcode == OP_I:   state_nxt = S_EXECUTEI;
                    i_opcode == OP_B:   state_nxt = S_BRANCH;
                    i_opcode == OP_JAL: state_nxt = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                    !op_known:          state_nxt = S_HALT;
`else
                    !op_known:          state_nxt = S_FETCH;
`endif
                    default:            state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                o_aluSrcA = A_REG1;
                o_aluSrcB = B_IMM;
                state_nxt = (i_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                o_adrSrc  = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                o_resultSrc = RES_DMEM;
                o_regWrite  = 1'b1;
                o_retire    = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_MEMWRITE: begin
                o_adrSrc   = 1'b1;
                o_memWrite = 1'b1;
                o_retire   = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_EXECUTER: begin
                o_aluSrcA = A_REG1;
                o_aluSrcB = B_REG2;
                o_aluOp   = f3_legal ? {i_funct7b5, i_funct3} : ALU_ADD;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                o_aluSrcA = A_REG1;
                o_aluSrcB = B_IMM;
                o_aluOp   = f3_legal ? {1'b0, i_funct3} : ALU_ADD;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                o_regWrite = 1'b1;
                o_retire   = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                o_aluSrcA = A_REG1;
                o_aluSrcB = B_REG2;
                o_aluOp   = ALU_SUB;
                o_pcWrite = (i_funct3 == 3'b000) ? i_zero :
                            (i_funct3 == 3'b001) ? !i_zero : 1'b0;
                o_retire  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                o_aluSrcA = A_OLDPC;
                o_aluSrcB = B_FOUR;
                o_pcWrite = 1'b1;
                state_nxt = S_ALUWB;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_HALT: state_nxt = S_HALT;
`endif
            default: state_nxt = S_FETCH;
        endcase
        // Reset suppresses every side effect in the cycle it is asserted.
        if (i_srst) begin
            o_pcWrite   = 1'b0;
            o_adrSrc    = 1'b0;
            o_memWrite  = 1'b0;
            o_irWrite   = 1'b0;
            o_regWrite  = 1'b0;
            o_resultSrc = RES_ALU;
            o_aluSrcA   = A_PC;
            o_aluSrcB   = B_REG2;
            o_aluOp     = ALU_ADD;
            o_retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: directed and random
// instructions against a per-instruction cycle-table reference model.
module tb_riscv_multicycle_ctrl;

    logic       i_clk = 1'b0;
    logic       i_srst;
    logic [6:0] i_opcode;
    logic [2:0] i_funct3;
    logic       i_funct7b5;
    logic       i_zero;
    logic       o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite;
    logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB;
    logic [3:0] o_aluOp;
    logic       o_retire, o_illegal;

    int tests = 0;
    int fails = 0;
    logic illegal_exp = 1'b0;
    logic [15:0] exp_q[$];

    riscv_multicycle_ctrl dut (
        .i_clk(i_clk), .i_srst(i_srst), .i_opcode(i_opcode),
        .i_funct3(i_funct3), .i_funct7b5(i_funct7b5), .i_zero(i_zero),
        .o_pcWrite(o_pcWrite), .o_adrSrc(o_adrSrc), .o_memWrite(o_memWrite),
        .o_irWrite(o_irWrite), .o_regWrite(o_regWrite),
        .o_resultSrc(o_resultSrc), .o_aluSrcA(o_aluSrcA),
        .o_aluSrcB(o_aluSrcB), .o_aluOp(o_aluOp), .o_retire(o_retire),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    logic [16:0] obs;
    assign obs = {o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite,
                  o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluOp, o_retire,
                  o_illegal};

    function automatic logic [15:0] mk(
        input logic pcw, input logic adr, input logic mw, input logic irw,
        input logic rw, input logic [1:0] res, input logic [1:0] sa,
        input logic [1:0] sb, input logic [3:0] op, input logic ret);
        return {pcw, adr, mw, irw, rw, res, sa, sb, op, ret};
    endfunction

    function automatic logic legal3(input logic [2:0] f3);
        return f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd4 ||
               f3 == 3'd6 || f3 == 3'd7;
    endfunction

    function automatic logic known(input logic [6:0] op);
        return op == 7'h03 || op == 7'h23 || op == 7'h33 ||
               op == 7'h13 || op == 7'h63 || op == 7'h6f;
    endfunction

    // Expected output of every cycle of one instruction, FETCH first.
    task automatic build(input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic z);
        logic [15:0] wb;
        logic bt;
        exp_q.delete();
        exp_q.push_back(mk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 4'd0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 4'd0, 0));
        wb = mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 1);
        case (op)
            7'h03: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 4'd0, 0));
                exp_q.push_back(mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 4'd0, 1));
            end
            7'h23: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 4'd0, 0));
                exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 1));
            end
            7'h33: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0,
                                   legal3(f3) ? {f7, f3} : 4'd0, 0));
                exp_q.push_back(wb);
            end
            7'h13: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1,
                                   legal3(f3) ? {1'b0, f3} : 4'd0, 0));
                exp_q.push_back(wb);
            end
            7'h63: begin
                bt = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0;
                exp_q.push_back(mk(bt, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0,
                                   4'b1000, 1));
            end
            7'h6f: begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 4'd0, 0));
                exp_q.push_back(wb);
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [16:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 with the FSM in FETCH; leaves at the next FETCH.
    task automatic run_instr(input string name, input logic [6:0] op,
                             input logic [2:0] f3, input logic f7,
                             input logic z);
        build(op, f3, f7, z);
        i_opcode   = op;
        i_funct3   = f3;
        i_funct7b5 = f7;
        i_zero     = z;
        foreach (exp_q[i]) begin
            #1;
            chk($sformatf("%s_c%0d", name, i), {exp_q[i], illegal_exp});
            @(posedge i_clk);
            #1;
`ifdef ILLEGAL_OP_TRAP_EN
            if (i == 1 && !known(op)) illegal_exp = 1'b1;
`endif
        end
    endtask

    initial begin
        logic [6:0] op;
        logic [16:0] zero_v;
        zero_v     = '0;
        i_srst     = 1'b1;
        i_opcode   = 7'h03;
        i_funct3   = 3'd2;
        i_funct7b5 = 1'b0;
        i_zero     = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_hold", zero_v);
        i_srst = 1'b0;

        run_instr("lw", 7'h03, 3'd2, 1'b0, 1'b0);

        repeat (3) @(posedge i_clk);
        #1;
        i_srst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("midlw_rst%0d", c), zero_v);
            @(posedge i_clk);
            #1;
        end
        i_srst = 1'b0;

        run_instr("lw_after_rst", 7'h03, 3'd2, 1'b0, 1'b0);
        run_instr("sub", 7'h33, 3'd0, 1'b1, 1'b0);
        run_instr("addi_f7", 7'h13, 3'd0, 1'b1, 1'b0);
        run_instr("r_badf3", 7'h33, 3'd1, 1'b1, 1'b0);
        run_instr("beq_t", 7'h63, 3'd0, 1'b0, 1'b1);
        run_instr("beq_nt", 7'h63, 3'd0, 1'b0, 1'b0);
        run_instr("bne_t", 7'h63, 3'd1, 1'b0, 1'b0);
        run_instr("bne_nt", 7'h63, 3'd1, 1'b0, 1'b1);
        run_instr("blt", 7'h63, 3'd4, 1'b0, 1'b1);
        run_instr("sw", 7'h23, 3'd2, 1'b0, 1'b0);
        run_instr("jal", 7'h6f, 3'd5, 1'b1, 1'b1);
`ifndef ILLEGAL_OP_TRAP_EN
        run_instr("unk", 7'h7f, 3'd0, 1'b0, 1'b0);
        run_instr("after_unk", 7'h13, 3'd4, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 6))
                0: op = 7'h03;
                1: op = 7'h23;
                2: op = 7'h33;
                3: op = 7'h13;
                4: op = 7'h63;
                5: op = 7'h6f;
                default: begin
                    op = 7'($urandom_range(0, 127));
                    while (known(op)) op = 7'($urandom_range(0, 127));
`ifdef ILLEGAL_OP_TRAP_EN
                    op = 7'h03;
`endif
                end
            endcase
            run_instr($sformatf("rnd%0d", n), op, 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef ILLEGAL_OP_TRAP_EN
        run_instr("trap", 7'h7f, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            i_opcode = 7'h03;
            #1;
            chk($sformatf("halt%0d", c), 17'h1);
            @(posedge i_clk);
            #1;
        end
        i_srst = 1'b1;
        @(posedge i_clk);
        #1;
        illegal_exp = 1'b0;
        chk("halt_rst", zero_v);
        i_srst = 1'b0;
        run_instr("lw_after_halt", 7'h03, 3'd2, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
